mux_cont_sel: RTL and testbench
===============================

Name: mux_cont_sel

Overview:
- Parameterized 2:1 selector: output b carries a when sel=0 and c when sel=1.
- Main output b is purely combinational, with zero latency and no dependence on clock or reset.
- A registered copy and a valid flag are provided for downstream clocked logic.
- Optional statistics counter tracks select toggles.
- Used as a leaf datapath steering element.

Parameters:
- WIDTH, 1, bit width of a, c, b, b_q.
- CNT_W, 8, width of the select-toggle counter (optional feature only).

Ports:
- clk  input  1  rising-edge clock for registered outputs.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  data input, selected when sel=0.
- c  input  WIDTH  data input, selected when sel=1.
- sel  input  1  select: 0 -> a, 1 -> c.
- en  input  1  capture enable for b_q.
- b  output  WIDTH  combinational mux output.
- b_q  output  WIDTH  registered mux output.
- b_q_vld  output  1  b_q holds data captured since reset.
- sel_cnt  output  CNT_W  select-toggle count (present only with MUX_CONT_STATS_EN).

Behaviour:
- b = sel ? c : a, continuously.
- b reacts within the same delta to any change on a, c or sel.
- b is unaffected by rst_n and clk.
- An X/Z on sel with a == c yields b = a; otherwise b is X.
- Reset: rst_n low forces b_q=0, b_q_vld=0 and the sel_cnt/last-sel registers to 0 immediately (asynchronous).
- Reset release is synchronous to the next rising clk edge; the first capture happens on the first edge with rst_n high.
- Rising clk with en=1: b_q <= (sel ? c : a) sampled at the edge; b_q_vld <= 1.
- Rising clk with en=0: b_q and b_q_vld hold.
- Latency: b is 0 cycles; b_q is 1 cycle after inputs are sampled with en=1.
- b_q_vld stays 1 until the next reset; it is never cleared by en=0.
- Reset asserted mid-operation clears b_q/b_q_vld at once; b keeps tracking inputs.
- All WIDTH bits share the single sel; no per-bit select.

Optional Feature:
- Macro: MUX_CONT_STATS_EN.
- With the macro defined:
  - A register last_sel samples sel every rising clk.
  - sel_cnt increments by 1 on each clk edge where sel != last_sel.
  - sel_cnt saturates at all-ones and does not wrap.
  - last_sel and sel_cnt reset to 0 asynchronously.
  - The first edge after reset compares against last_sel=0.
- Without the macro: the sel_cnt port and counter logic are absent; all other behaviour is identical.

Test Plan:
- a=1, c=0, sel=0, wait 10 -> b=1.
- a=0, c=1, sel=1, wait 10 -> b=1.
- a=0, c=0, sel=0, wait 10 -> b=0.
- a=1, c=1, sel=1, wait 10 -> b=1.
- rst_n=0 then 1, b_q_vld=0 before the first en edge; a=1, c=0, sel=0, en=1, one clk -> b_q=1, b_q_vld=1.
- en=0 with a changed to 0 over several clks -> b_q holds 1 while b follows a.
- Assert rst_n mid-cycle -> b_q=0 and b_q_vld=0 immediately, with no clk edge.
- With MUX_CONT_STATS_EN: toggle sel on 5 consecutive clks -> sel_cnt=5.
- With MUX_CONT_STATS_EN and CNT_W=2: 6 toggles -> sel_cnt=3 (saturated).

Source files
------------

// File: rtl/mux_cont_sel.sv
// mux_cont_sel: 2:1 steering mux with combinational, registered and valid outputs
// Ports: clk, rst_n (async active-low); a/c data, sel picks c when high; en captures b_q.
//        b = sel ? c : a (combinational); b_q registered copy; b_q_vld set on first capture.
// Optional: define MUX_CONT_STATS_EN to add sel_cnt, a saturating count of sel toggles.
module mux_cont_sel #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] c,
  input  logic             sel,
  input  logic             en,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] b_q,
`ifdef MUX_CONT_STATS_EN
  output logic             b_q_vld,
  output logic [CNT_W-1:0] sel_cnt
`else
  output logic             b_q_vld
`endif
);
  logic [WIDTH-1:0] b_q_d;
  logic             vld_d;
  assign b = sel ? c : a;
  always_comb begin
    b_q_d = en ? b : b_q;
    vld_d = en | b_q_vld;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_q     <= '0;
      b_q_vld <= 1'b0;
    end else begin
      b_q     <= b_q_d;
      b_q_vld <= vld_d;
    end
  end
`ifdef MUX_CONT_STATS_EN
  logic             last_sel_q;
  logic [CNT_W-1:0] sel_cnt_q, sel_cnt_d;
  // saturate at all-ones instead of wrapping
  always_comb sel_cnt_d = (sel != last_sel_q && !(&sel_cnt_q)) ? sel_cnt_q + 1'b1 : sel_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_sel_q <= 1'b0;
      sel_cnt_q  <= '0;
    end else begin
      last_sel_q <= sel;
      sel_cnt_q  <= sel_cnt_d;
    end
  end
  assign sel_cnt = sel_cnt_q;
`endif
endmodule

// File: tb/tb_mux_cont_sel.sv
// tb_mux_cont_sel: directed self-checking bench for mux_cont_sel
module tb_mux_cont_sel;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a = 1'b0, c = 1'b0, sel = 1'b0, en = 1'b0;
  logic b, b_q, b_q_vld;
  int   passed = 0;
  int   total = 0;
  always #5 clk = ~clk;
`ifdef MUX_CONT_STATS_EN
  logic [7:0] sel_cnt;
  logic [1:0] sel_cnt2;
  logic       b2, b_q2, b_q_vld2;
  mux_cont_sel #(.WIDTH(1), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .c(c), .sel(sel), .en(en),
    .b(b), .b_q(b_q), .b_q_vld(b_q_vld), .sel_cnt(sel_cnt));
  mux_cont_sel #(.WIDTH(1), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .a(a), .c(c), .sel(sel), .en(en),
    .b(b2), .b_q(b_q2), .b_q_vld(b_q_vld2), .sel_cnt(sel_cnt2));
`else
  mux_cont_sel #(.WIDTH(1), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .c(c), .sel(sel), .en(en),
    .b(b), .b_q(b_q), .b_q_vld(b_q_vld));
`endif

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; a = 1'b0; c = 1'b0; sel = 1'b0;
    #1;
    total++; if (b_q !== 1'b0) $display("FAIL reset_b_q got %b want 0", b_q); else passed++;
    total++; if (b_q_vld !== 1'b0) $display("FAIL reset_vld got %b want 0", b_q_vld); else passed++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (b_q_vld !== 1'b0) $display("FAIL vld_no_en got %b want 0", b_q_vld); else passed++;
  endtask

  task automatic test_comb();
    logic [2:0] vec [4] = '{3'b100, 3'b011, 3'b000, 3'b111};
    logic       exp [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      {a, c, sel} = vec[i];
      #10;
      total++; if (b !== exp[i]) $display("FAIL comb_%0d got %b want %b", i, b, exp[i]); else passed++;
    end
    rst_n = 1'b0; a = 1'b0; c = 1'b1; sel = 1'b1;
    #1;
    total++; if (b !== 1'b1) $display("FAIL comb_in_reset got %b want 1", b); else passed++;
    @(negedge clk); rst_n = 1'b1; sel = 1'b0;
  endtask

  task automatic test_capture();
    @(negedge clk); a = 1'b1; c = 1'b0; sel = 1'b0; en = 1'b1;
    @(posedge clk); #1;
    total++; if (b_q !== 1'b1) $display("FAIL cap_a got %b want 1", b_q); else passed++;
    total++; if (b_q_vld !== 1'b1) $display("FAIL cap_vld got %b want 1", b_q_vld); else passed++;
    @(negedge clk); en = 1'b0; a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (b_q !== 1'b1) $display("FAIL hold_b_q got %b want 1", b_q); else passed++;
    total++; if (b !== 1'b0) $display("FAIL hold_b got %b want 0", b); else passed++;
    total++; if (b_q_vld !== 1'b1) $display("FAIL hold_vld got %b want 1", b_q_vld); else passed++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk); a = 1'b1; c = 1'b0; sel = 1'b1; en = 1'b1;
    @(posedge clk); #1;
    total++; if (b_q !== 1'b0) $display("FAIL b2b_c0 got %b want 0", b_q); else passed++;
    @(negedge clk); a = 1'b0; c = 1'b1;
    @(posedge clk); #1;
    total++; if (b_q !== 1'b1) $display("FAIL b2b_c1 got %b want 1", b_q); else passed++;
    @(negedge clk); en = 1'b0; sel = 1'b0;
  endtask

  task automatic test_async_reset();
    @(negedge clk); a = 1'b1; sel = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++; if (b_q !== 1'b0) $display("FAIL async_b_q got %b want 0", b_q); else passed++;
    total++; if (b_q_vld !== 1'b0) $display("FAIL async_vld got %b want 0", b_q_vld); else passed++;
    total++; if (b !== 1'b1) $display("FAIL async_b got %b want 1", b); else passed++;
    @(negedge clk); rst_n = 1'b1;
  endtask

`ifdef MUX_CONT_STATS_EN
  task automatic test_stats();
    rst_n = 1'b0; sel = 1'b0; en = 1'b0;
    #1;
    total++; if (sel_cnt !== 8'd0) $display("FAIL cnt_reset got %0d want 0", sel_cnt); else passed++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (sel_cnt !== 8'd0) $display("FAIL cnt_steady got %0d want 0", sel_cnt); else passed++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); sel = ~sel;
    end
    @(posedge clk); #1;
    total++; if (sel_cnt !== 8'd5) $display("FAIL cnt_5 got %0d want 5", sel_cnt); else passed++;
    total++; if (sel_cnt2 !== 2'd3) $display("FAIL cnt2_5 got %0d want 3", sel_cnt2); else passed++;
    @(negedge clk); sel = ~sel;
    @(posedge clk); #1;
    total++; if (sel_cnt !== 8'd6) $display("FAIL cnt_6 got %0d want 6", sel_cnt); else passed++;
    total++; if (sel_cnt2 !== 2'd3) $display("FAIL cnt2_sat got %0d want 3", sel_cnt2); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_comb();
    test_capture();
    test_back_to_back();
    test_async_reset();
`ifdef MUX_CONT_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
